// File: rtl/sn74ls590s.sv
// WIDTH-bit up-counter with an output storage register and a 3-state bus.
// Runs on a single clock; the timing parameters document the TTL part's delays.
module sn74ls590s #(
  parameter int WIDTH    = 8,
  parameter int tPLH_min = 0,
  parameter int tPLH_typ = 15,
  parameter int tPLH_max = 23,
  parameter int tPHL_min = 0,
  parameter int tPHL_typ = 20,
  parameter int tPHL_max = 30,
  parameter int tPZH_min = 0,
  parameter int tPZH_typ = 31,
  parameter int tPZH_max = 47,
  parameter int tPZL_min = 0,
  parameter int tPZL_typ = 31,
  parameter int tPZL_max = 47
) (
  input  logic             cck,
  input  logic             cclr,
  input  logic             ccken,
  input  logic             rcken,
  input  logic             g_,
  output logic [WIDTH-1:0] q,
  output logic             rco_
);

  // Reject impossible widths and delay triples when the part is elaborated.
  if (WIDTH < 2 ||
      tPLH_min > tPLH_typ || tPLH_typ > tPLH_max ||
      tPHL_min > tPHL_typ || tPHL_typ > tPHL_max ||
      tPZH_min > tPZH_typ || tPZH_typ > tPZH_max ||
      tPZL_min > tPZL_typ || tPZL_typ > tPZL_max) begin : g_bad_param
    $error("sn74ls590s: illegal parameter set");
  end

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] oreg_r;

  // Reset wins; otherwise capture (pre-edge count) and count act independently.
  always_ff @(posedge cck) begin
    if (!cclr) begin
      cnt_r  <= {WIDTH{1'b0}};
      oreg_r <= {WIDTH{1'b0}};
    end else begin
      if (rcken) begin
        oreg_r <= cnt_r;
      end else begin
        oreg_r <= oreg_r;
      end
      if (!ccken) begin
        cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Terminal-count decode is ungated so stages can be chained through ccken.
  assign rco_ = ~(&cnt_r);

  assign q = g_ ? {WIDTH{1'bz}} : oreg_r;

endmodule

// File: tb/tb_sn74ls590s.sv
// Directed bench for sn74ls590s: reset, count/wrap, capture, hold, 3-state, cascade.
// The main bus has pull-ups so a released bus reads as all ones.
module tb_sn74ls590s;

  logic cck = 1'b0;
  logic cclr, ccken, rcken, g_;
  tri   [7:0] q_bus;
  logic rco_;

  logic casc_en, casc_clr, casc_cap;
  logic [7:0] q_lo, q_hi;
  logic rco_lo, rco_hi;

  int checks = 0;
  int errors = 0;

  always #5 cck = ~cck;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (q_bus[i]);
  end

  sn74ls590s #(.WIDTH(8)) dut (
    .cck(cck), .cclr(cclr), .ccken(ccken), .rcken(rcken), .g_(g_),
    .q(q_bus), .rco_(rco_)
  );

  sn74ls590s #(.WIDTH(8)) lo (
    .cck(cck), .cclr(casc_clr), .ccken(casc_en), .rcken(casc_cap), .g_(1'b0),
    .q(q_lo), .rco_(rco_lo)
  );

  sn74ls590s #(.WIDTH(8)) hi (
    .cck(cck), .cclr(casc_clr), .ccken(rco_lo), .rcken(casc_cap), .g_(1'b0),
    .q(q_hi), .rco_(rco_hi)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then return on the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(posedge cck);
    @(negedge cck);
  endtask

  // Snapshot the main counter into oreg without counting.
  task automatic capture();
    rcken = 1'b1; ccken = 1'b1;
    edges(1);
    rcken = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cclr = 1'b1; ccken = 1'b1; rcken = 1'b0; g_ = 1'b0;
    casc_en = 1'b1; casc_clr = 1'b0; casc_cap = 1'b0;
    @(negedge cck);

    // Reset with capture and count requested: reset wins.
    cclr = 1'b0; ccken = 1'b0; rcken = 1'b1;
    edges(1);
    check("reset_q", q_bus, 8'h00);
    check("reset_rco", {7'd0, rco_}, 8'h01);

    // Count up to terminal count, then wrap.
    cclr = 1'b1; rcken = 1'b0; ccken = 1'b0;
    edges(255);
    check("tc_rco", {7'd0, rco_}, 8'h00);
    check("tc_q_uncaptured", q_bus, 8'h00);
    edges(1);
    check("wrap_rco", {7'd0, rco_}, 8'h01);
    check("wrap_q", q_bus, 8'h00);
    capture();
    check("wrap_cnt", q_bus, 8'h00);

    // Count to 0x41, then capture and count on the same edge.
    ccken = 1'b0;
    edges(8'h41);
    rcken = 1'b1; ccken = 1'b0;
    edges(1);
    check("simul_q", q_bus, 8'h41);
    capture();
    check("simul_cnt", q_bus, 8'h42);

    // Move to 0x7F and hold for 10 edges while pulsing capture.
    ccken = 1'b0;
    edges(8'h3D);
    ccken = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rcken = i[0];
      edges(1);
    end
    rcken = 1'b0;
    check("hold_rco", {7'd0, rco_}, 8'h01);
    check("hold_q", q_bus, 8'h7F);
    capture();
    check("hold_cnt", q_bus, 8'h7F);

    // Release the bus; counter keeps running underneath.
    g_ = 1'b1;
    #1;
    check("hiz_q", q_bus, 8'hFF);
    ccken = 1'b0;
    edges(1);
    ccken = 1'b1;
    check("hiz_q_after_count", q_bus, 8'hFF);
    g_ = 1'b0;
    #31;
    check("reenable_q", q_bus, 8'h7F);
    @(negedge cck);
    capture();
    check("reenable_cnt", q_bus, 8'h80);

    // Terminal count is decoded regardless of ccken.
    ccken = 1'b0;
    edges(8'h7F);
    ccken = 1'b1;
    edges(2);
    check("tc_held_rco", {7'd0, rco_}, 8'h00);

    // Reset mid-operation, then resume counting from zero.
    cclr = 1'b0; rcken = 1'b1; ccken = 1'b0;
    edges(1);
    cclr = 1'b1; rcken = 1'b0; ccken = 1'b1;
    check("midreset_q", q_bus, 8'h00);
    check("midreset_rco", {7'd0, rco_}, 8'h01);
    ccken = 1'b0;
    edges(1);
    capture();
    check("resume_cnt", q_bus, 8'h01);

    // Cascade: 256 low-stage edges carry one count into the high stage.
    casc_clr = 1'b0;
    edges(1);
    casc_clr = 1'b1; casc_en = 1'b0;
    edges(256);
    casc_en = 1'b1; casc_cap = 1'b1;
    edges(1);
    casc_cap = 1'b0;
    check("casc_lo", q_lo, 8'h00);
    check("casc_hi", q_hi, 8'h01);

    // Reset mid-count clears both stages together.
    casc_en = 1'b0;
    edges(300);
    check("casc_mid_lo_rco", {7'd0, rco_lo}, 8'h01);
    casc_clr = 1'b0;
    edges(1);
    casc_clr = 1'b1; casc_en = 1'b1; casc_cap = 1'b1;
    edges(1);
    casc_cap = 1'b0;
    check("casc_rst_lo", q_lo, 8'h00);
    check("casc_rst_hi", q_hi, 8'h00);
    check("casc_rst_hi_rco", {7'd0, rco_hi}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
